ramc_load_addr_gen: RTL and testbench

- Upstream stage for the twiddle-table loader.
- Sweeps the dual-port twiddle ROM address space in even/odd pairs on addr_a/addr_b.
- Holds each pair long enough for the registered ROM output to match the address being written into the twiddle register array.
- Terminates the sweep by asserting bit [AW-1] of addr_a, which freezes the downstream loader. Exposes a start/busy/done handshake to the NTT top-level controller.

---
 rtl/ntt_load_pkg.sv | 26 ++
 rtl/ramc_load_addr_gen.sv | 118 +++++++++++
 tb/tb_ramc_load_addr_gen.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/ntt_load_pkg.sv
// Shared types and width helpers for the twiddle-table load path.
package ntt_load_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } load_state_t;

    localparam int TW_DEPTH = 128;

    // Entry address plus one MSB used as the load-complete flag.
    function automatic int addr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Pair counter indexes DEPTH/2 even/odd pairs.
    function automatic int pair_width(input int depth);
        return $clog2(depth) - 1;
    endfunction

    function automatic int dwell_width(input int rom_lat);
        return ($clog2(rom_lat + 1) < 1) ? 1 : $clog2(rom_lat + 1);
    endfunction

endpackage

// File: rtl/ramc_load_addr_gen.sv
// Sweeps the twiddle ROM in even/odd address pairs, holding each pair for
// ROM_LAT+1 cycles, then parks both addresses on the load-complete flag.
module ramc_load_addr_gen
    import ntt_load_pkg::*;
#(
    parameter int DEPTH   = TW_DEPTH,
    parameter int ROM_LAT = 1,
    parameter int AW      = addr_width(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    output logic [AW-1:0] addr_a,
    output logic [AW-1:0] addr_b,
    output logic          busy,
    output logic          done,
    output logic [1:0]    state_dbg
);

    localparam int KW = pair_width(DEPTH);
    localparam int DW = dwell_width(ROM_LAT);

    localparam logic [KW-1:0] K_LAST    = KW'(DEPTH / 2 - 1);
    localparam logic [DW-1:0] D_LAST    = DW'(ROM_LAT);
    localparam logic [AW-1:0] IDLE_A    = '0;
    localparam logic [AW-1:0] IDLE_B    = AW'(1);
    localparam logic [AW-1:0] FLAG_ADDR = {1'b1, {(AW-1){1'b0}}};

    load_state_t   state, state_n;
    logic [KW-1:0] k, k_n;
    logic [DW-1:0] d, d_n;
    logic [AW-1:0] addr_a_n, addr_b_n;
    logic          busy_n, done_n;

    assign state_dbg = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            k      <= '0;
            d      <= '0;
            addr_a <= IDLE_A;
            addr_b <= IDLE_B;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_n;
            k      <= k_n;
            d      <= d_n;
            addr_a <= addr_a_n;
            addr_b <= addr_b_n;
            busy   <= busy_n;
            done   <= done_n;
        end
    end

    // Outputs are registered from next-state values so they line up with state.
    always_comb begin
        state_n  = state;
        k_n      = k;
        d_n      = d;
        addr_a_n = addr_a;
        addr_b_n = addr_b;
        busy_n   = busy;
        done_n   = done;
        case (state)
            IDLE: begin
                k_n      = '0;
                d_n      = '0;
                addr_a_n = IDLE_A;
                addr_b_n = IDLE_B;
                busy_n   = 1'b0;
                done_n   = 1'b0;
                if (start && !abort) begin
                    state_n = LOAD;
                    busy_n  = 1'b1;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_n  = IDLE;
                    k_n      = '0;
                    d_n      = '0;
                    addr_a_n = IDLE_A;
                    addr_b_n = IDLE_B;
                    busy_n   = 1'b0;
                end else if (d == D_LAST) begin
                    d_n = '0;
                    if (k == K_LAST) begin
                        state_n  = DONE;
                        addr_a_n = FLAG_ADDR;
                        addr_b_n = FLAG_ADDR;
                        busy_n   = 1'b0;
                        done_n   = 1'b1;
                    end else begin
                        k_n      = k + 1'b1;
                        addr_a_n = AW'({k + 1'b1, 1'b0});
                        addr_b_n = AW'({k + 1'b1, 1'b1});
                    end
                end else begin
                    d_n = d + 1'b1;
                end
            end
            DONE: begin
                // Terminal: the downstream loader has frozen on the flag.
                addr_a_n = FLAG_ADDR;
                addr_b_n = FLAG_ADDR;
                busy_n   = 1'b0;
                done_n   = 1'b1;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ramc_load_addr_gen.sv
// Directed bench: default instance (DEPTH=128, ROM_LAT=1) and a small one (DEPTH=16, ROM_LAT=2).
module tb_ramc_load_addr_gen;

    logic clk = 1'b0;
    logic reset = 1'b0;

    logic       start_a = 1'b0, abort_a = 1'b0;
    logic [7:0] addr_a_a, addr_b_a;
    logic       busy_a, done_a;
    logic [1:0] st_a;

    logic       start_b = 1'b0, abort_b = 1'b0;
    logic [4:0] addr_a_b, addr_b_b;
    logic       busy_b, done_b;
    logic [1:0] st_b;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ramc_load_addr_gen u_dut_a (
        .clk(clk), .reset(reset), .start(start_a), .abort(abort_a),
        .addr_a(addr_a_a), .addr_b(addr_b_a), .busy(busy_a), .done(done_a),
        .state_dbg(st_a)
    );

    ramc_load_addr_gen #(.DEPTH(16), .ROM_LAT(2)) u_dut_b (
        .clk(clk), .reset(reset), .start(start_b), .abort(abort_b),
        .addr_a(addr_a_b), .addr_b(addr_b_b), .busy(busy_b), .done(done_b),
        .state_dbg(st_b)
    );

    task automatic check_a(input string name, input logic [7:0] ea, input logic [7:0] eb,
                           input logic ebusy, input logic edone);
        checks++;
        if (addr_a_a !== ea || addr_b_a !== eb || busy_a !== ebusy || done_a !== edone) begin
            failures++;
            $display("FAIL %s: got a=%h b=%h busy=%b done=%b, want a=%h b=%h busy=%b done=%b",
                     name, addr_a_a, addr_b_a, busy_a, done_a, ea, eb, ebusy, edone);
        end
    endtask

    task automatic check_b(input string name, input logic [4:0] ea, input logic [4:0] eb,
                           input logic ebusy, input logic edone);
        checks++;
        if (addr_a_b !== ea || addr_b_b !== eb || busy_b !== ebusy || done_b !== edone) begin
            failures++;
            $display("FAIL %s: got a=%h b=%h busy=%b done=%b, want a=%h b=%h busy=%b done=%b",
                     name, addr_a_b, addr_b_b, busy_b, done_b, ea, eb, ebusy, edone);
        end
    endtask

    // Pulse start on instance A, then check every cycle through the DONE cycle.
    task automatic sweep_a(input string tag);
        logic [7:0] ea;
        @(negedge clk);
        start_a = 1'b1;
        for (int i = 1; i <= 129; i++) begin
            @(negedge clk);
            start_a = 1'b0;
            if (i <= 128) begin
                ea = 8'(((i - 1) / 2) * 2);
                check_a(tag, ea, ea + 8'd1, 1'b1, 1'b0);
            end else begin
                check_a({tag, "_done"}, 8'h80, 8'h80, 1'b0, 1'b1);
            end
        end
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        #1;
        check_a("reset_async_a", 8'h00, 8'h01, 1'b0, 1'b0);
        check_b("reset_async_b", 5'h00, 5'h01, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_a("reset_release_a", 8'h00, 8'h01, 1'b0, 1'b0);
        check_b("reset_release_b", 5'h00, 5'h01, 1'b0, 1'b0);
    endtask

    task automatic test_full_load();
        sweep_a("full_load");
    endtask

    task automatic test_small_config();
        logic [4:0] ea;
        @(negedge clk);
        start_b = 1'b1;
        for (int i = 1; i <= 25; i++) begin
            @(negedge clk);
            start_b = 1'b0;
            if (i <= 24) begin
                ea = 5'(((i - 1) / 3) * 2);
                check_b("small_load", ea, ea + 5'd1, 1'b1, 1'b0);
            end else begin
                check_b("small_done", 5'h10, 5'h10, 1'b0, 1'b1);
            end
        end
        repeat (3) @(negedge clk);
        check_b("small_done_hold", 5'h10, 5'h10, 1'b0, 1'b1);
    endtask

    task automatic test_ignored_in_done();
        // Instance A is in DONE after the full load.
        start_a = 1'b1;
        abort_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        abort_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_a("done_ignores_inputs", 8'h80, 8'h80, 1'b0, 1'b1);
        end
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_a("reset_from_done", 8'h00, 8'h01, 1'b0, 1'b0);
    endtask

    task automatic test_simultaneous();
        start_a = 1'b1;
        abort_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        abort_a = 1'b0;
        check_a("start_abort_idle", 8'h00, 8'h01, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        check_a("start_abort_idle_hold", 8'h00, 8'h01, 1'b0, 1'b0);
    endtask

    task automatic test_abort();
        @(negedge clk);
        start_a = 1'b1;
        for (int i = 1; i <= 33; i++) begin
            @(negedge clk);
            start_a = 1'b0;
        end
        // Pair 16 occupies cycles 33..34 after start.
        check_a("abort_pre", 8'h20, 8'h21, 1'b1, 1'b0);
        abort_a = 1'b1;
        @(negedge clk);
        abort_a = 1'b0;
        check_a("abort_post", 8'h00, 8'h01, 1'b0, 1'b0);
        @(negedge clk);
        check_a("abort_idle", 8'h00, 8'h01, 1'b0, 1'b0);
        sweep_a("after_abort");
    endtask

    task automatic test_reset_mid_load();
        reset_pulse();
        @(negedge clk);
        start_a = 1'b1;
        for (int i = 1; i <= 65; i++) begin
            @(negedge clk);
            start_a = 1'b0;
        end
        check_a("mid_pre", 8'h40, 8'h41, 1'b1, 1'b0);
        #2 reset = 1'b1;
        #1;
        check_a("mid_async_reset", 8'h00, 8'h01, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_a("mid_reset_release", 8'h00, 8'h01, 1'b0, 1'b0);
        sweep_a("after_reset");
    endtask

    initial begin
        test_reset();
        test_full_load();
        test_small_config();
        test_ignored_in_done();
        reset_pulse();
        test_simultaneous();
        test_abort();
        test_reset_mid_load();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
